// File: rtl/wptr_full_if.sv
// Write-side bus of the async FIFO write-pointer block: producer request, synchronized read pointer, status.
// Overflow signals exist only when WPTR_FULL_OVERFLOW_EN is defined.
interface wptr_full_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  i_winc;
   logic [ADDR_WIDTH:0]   i_wq2_rptr;
   logic                  o_wen;
   logic [ADDR_WIDTH-1:0] o_waddr;
   logic [ADDR_WIDTH:0]   o_wptr;
   logic                  o_wfull;
   logic                  o_walmost_full;
   logic [ADDR_WIDTH:0]   o_wlevel;
`ifdef WPTR_FULL_OVERFLOW_EN
   logic                  i_wovf_clr;
   logic                  o_woverflow;

   modport slave (
      input  i_winc, i_wq2_rptr, i_wovf_clr,
      output o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wlevel, o_woverflow
   );
   modport master (
      output i_winc, i_wq2_rptr, i_wovf_clr,
      input  o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wlevel, o_woverflow
   );
`else
   modport slave (
      input  i_winc, i_wq2_rptr,
      output o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wlevel
   );
   modport master (
      output i_winc, i_wq2_rptr,
      input  o_wen, o_waddr, o_wptr, o_wfull, o_walmost_full, o_wlevel
   );
`endif
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-side logic: binary/Gray write pointer, registered full, almost-full and fill level.
// Define WPTR_FULL_OVERFLOW_EN to add the sticky overflow flag and its clear input.
module wptr_full #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH - 1
) (
   input logic        i_wclk,
   input logic        i_wrst_n,
   wptr_full_if.slave wif
);
   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wbin_r;
   logic [PW-1:0] wgray_r;
   logic [PW-1:0] wlevel_r;
   logic          wfull_r;
   logic          wafull_r;
   logic          wen_s;
   logic [PW-1:0] wbin_next_s;
   logic [PW-1:0] wgray_next_s;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] level_next_s;
   logic [PW-1:0] full_cmp_s;
   logic          full_next_s;
   logic          afull_next_s;

   // Next pointer, level and flags; no write is ever granted while in reset
   always_comb begin
      wen_s        = wif.i_winc & ~wfull_r & i_wrst_n;
      wbin_next_s  = wbin_r + {{ADDR_WIDTH{1'b0}}, wen_s};
      wgray_next_s = {1'b0, wbin_next_s[PW-1:1]} ^ wbin_next_s;
      rbin_s       = gray2bin(wif.i_wq2_rptr);
      level_next_s = wbin_next_s - rbin_s;
      full_cmp_s   = {~wif.i_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wif.i_wq2_rptr[ADDR_WIDTH-2:0]};
      full_next_s  = (wgray_next_s == full_cmp_s);
      afull_next_s = (level_next_s >= PW'(AFULL_THRESH));
   end

   // Pointer, level and flag registers
   always_ff @(posedge i_wclk or negedge i_wrst_n) begin
      if (!i_wrst_n) begin
         wbin_r   <= {PW{1'b0}};
         wgray_r  <= {PW{1'b0}};
         wlevel_r <= {PW{1'b0}};
         wfull_r  <= 1'b0;
         wafull_r <= 1'b0;
      end else begin
         wbin_r   <= wbin_next_s;
         wgray_r  <= wgray_next_s;
         wlevel_r <= level_next_s;
         wfull_r  <= full_next_s;
         wafull_r <= afull_next_s;
      end
   end

`ifdef WPTR_FULL_OVERFLOW_EN
   logic wovf_r;

   // Sticky overflow: a write attempt while full sets it and wins over a clear
   always_ff @(posedge i_wclk or negedge i_wrst_n) begin
      if (!i_wrst_n) begin
         wovf_r <= 1'b0;
      end else if (wif.i_winc && wfull_r) begin
         wovf_r <= 1'b1;
      end else if (wif.i_wovf_clr) begin
         wovf_r <= 1'b0;
      end else begin
         wovf_r <= wovf_r;
      end
   end

   assign wif.o_woverflow = wovf_r;
`endif

   assign wif.o_wen          = wen_s;
   assign wif.o_waddr        = wbin_r[ADDR_WIDTH-1:0];
   assign wif.o_wptr         = wgray_r;
   assign wif.o_wfull        = wfull_r;
   assign wif.o_walmost_full = wafull_r;
   assign wif.o_wlevel       = wlevel_r;
endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter: ADDR_WIDTH, default 3, memory address width; FIFO depth = 2**ADDR_WIDTH.
REQ-002 Parameter: AFULL_THRESH, default 2**ADDR_WIDTH-1, fill level at or above which o_walmost_full asserts (legal range 1..2**ADDR_WIDTH).
REQ-003 i_wclk  input  1  write-domain clock; the only clock.
REQ-004 i_wrst_n  input  1  asynchronous, active-low reset.
REQ-005 i_winc  input  1  write request from the producer.
REQ-006 i_wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into i_wclk.
REQ-007 i_wovf_clr  input  1  clears the sticky overflow flag (present only with the macro).
REQ-008 o_wen  output  1  memory write enable.
REQ-009 o_waddr  output  ADDR_WIDTH  memory write address.
REQ-010 o_wptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-011 o_wfull  output  1  registered full flag.
REQ-012 o_walmost_full  output  1  registered almost-full flag.
REQ-013 o_wlevel  output  ADDR_WIDTH+1  registered conservative fill level, 0..2**ADDR_WIDTH.
REQ-014 o_woverflow  output  1  sticky overflow flag (present only with the macro).

Function
REQ-015 Internal binary write pointer wbin, ADDR_WIDTH+1 bits, wraps modulo 2**(ADDR_WIDTH+1).
REQ-016 o_wen = i_winc & ~o_wfull, combinational; a write is accepted only when o_wen=1.
REQ-017 wbin_next = wbin + o_wen; wgray_next = (wbin_next>>1) ^ wbin_next.
REQ-018 wbin and o_wptr load wbin_next and wgray_next on every i_wclk rising edge.
REQ-019 o_waddr = wbin[ADDR_WIDTH-1:0], taken directly from the register with no combinational path from i_winc.
REQ-020 o_wfull loads (wgray_next == {~i_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], i_wq2_rptr[ADDR_WIDTH-2:0]}) on each edge; the write that fills the FIFO raises o_wfull at that same edge.
REQ-021 rbin = Gray-to-binary of i_wq2_rptr; o_wlevel loads (wbin_next - rbin) mod 2**(ADDR_WIDTH+1) on each edge.
REQ-022 o_walmost_full loads (wbin_next - rbin) >= AFULL_THRESH on each edge.
REQ-023 A write attempted while full (i_winc=1, o_wfull=1) is dropped; wbin, o_wptr and o_wlevel hold.
REQ-024 Full deassertion is conservative: it follows read-side pops only after the synchronizer delay (at least 2 i_wclk cycles plus one register stage); the block never reports room that does not exist.
REQ-025 Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 is seamless; level and full stay correct across the wrap.
REQ-026 Exactly one bit of o_wptr changes per edge, and only when o_wen=1.

Reset
REQ-027 While i_wrst_n=0: wbin, o_wptr, o_wlevel = 0; o_wfull, o_walmost_full, o_woverflow = 0; this takes effect immediately, independent of i_wclk.
REQ-028 Reset asserted mid-operation discards in-flight state; the first write after release goes to o_waddr=0.

Configuration
REQ-029 Macro WPTR_FULL_OVERFLOW_EN: when defined, i_wovf_clr and o_woverflow exist; o_woverflow sets on any edge with i_winc=1 and o_wfull=1, and clears on an edge with i_wovf_clr=1 (set wins if both occur on the same edge).
REQ-030 When WPTR_FULL_OVERFLOW_EN is undefined, neither port exists and no overflow logic is synthesized; all other behaviour is identical.

Verification (ADDR_WIDTH=3, AFULL_THRESH=7)
REQ-031 Reset with i_winc=1 held -> all outputs 0 while reset is asserted, o_waddr=0 after release.
REQ-032 i_wq2_rptr=0, 8 consecutive writes -> after the 7th edge o_walmost_full=1 and o_wlevel=7; after the 8th edge o_wfull=1, o_wptr=4'b1100, o_wlevel=8.
REQ-033 While full, i_winc=1 for 3 cycles -> o_wen=0, o_wptr holds 4'b1100, o_woverflow=1 (macro on); one i_wovf_clr pulse with i_winc=0 -> o_woverflow=0.
REQ-034 While full, i_wq2_rptr steps to 4'b0011 (binary 2) -> on the next edge o_wfull=0, o_wlevel=6, o_walmost_full=0.
REQ-035 Continuous write/read streaming for more than 32 writes -> o_wptr wraps 4'b1000 to 4'b0000, one bit changes per edge, o_wlevel never exceeds 8, no false full.
REQ-036 Reset pulse after 5 writes -> o_wptr=0, o_wlevel=0, o_wfull=0 immediately; the next write goes to o_waddr=0.
